i2c_slave_rx_frontend: RTL and testbench

Consumes the serial bit stream of `I2C_slave_read_byte` (data/load/finish/error), assembles bytes MSB first, and runs the slave receive protocol. It decodes the address byte against `SLAVE_ADDR`, captures the R/W bit and requests ACKs. It also hands received data bytes to the register/FIFO side over a valid/ready handshake. It sits between the byte reader and the slave's ACK driver and register interface. It is the reader's sole driver of `go`.

---
 rtl/i2c_slave_rx_frontend.sv | 134 +++++++++++++
 tb/tb_i2c_slave_rx_frontend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_frontend.sv
// I2C slave receive front end: assembles bytes from the byte reader, decodes the
// address, requests ACKs and hands data bytes to the consumer over valid/ready.
module i2c_slave_rx_frontend #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_det,
   input  logic       stop_det,
   input  logic       bit_data,
   input  logic       bit_load,
   input  logic       byte_finish,
   input  logic       byte_error,
   output logic       rd_go,
   output logic       addr_match,
   output logic       rw,
   output logic       ack_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_CHK, DATA, DATA_DONE, WAIT_STOP
   } state_t;

   state_t     state, nxt;
   logic [7:0] sh, sh_d, rx_data_d;
   logic [3:0] bit_cnt, cnt_d;
   logic       match_d, rw_d, ack_d, rxv_d, ovf_d;
   logic       collecting, hit;

   assign collecting = (state == ADDR) || (state == DATA);
   assign hit        = (sh[7:1] == SLAVE_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (start_det)     nxt = ADDR;
      else if (stop_det) nxt = IDLE;
      else begin
         case (state)
            ADDR: begin
               if (byte_error)       nxt = IDLE;
               else if (byte_finish) nxt = (bit_cnt == 4'd8) ? ADDR_CHK : WAIT_STOP;
            end
            ADDR_CHK:  nxt = (hit && !sh[0]) ? DATA : WAIT_STOP;
            DATA: begin
               if (byte_error)       nxt = IDLE;
               else if (byte_finish) nxt = DATA_DONE;
            end
            DATA_DONE: nxt = DATA;
            default:   nxt = state;
         endcase
      end
   end

   // Next values for the registered outputs; START/STOP override the check cycles.
   always_comb begin
      ack_d     = 1'b0;
      match_d   = addr_match;
      rw_d      = rw;
      rxv_d     = rx_valid && !rx_ready;
      rx_data_d = rx_data;
      ovf_d     = overflow;
      sh_d      = sh;
      cnt_d     = bit_cnt;
      if (start_det) begin
         match_d = 1'b0;
         ovf_d   = 1'b0;
         cnt_d   = 4'd0;
      end else if (stop_det) begin
         match_d = 1'b0;
      end else begin
         case (state)
            ADDR_CHK: begin
               match_d = hit;
               if (hit) begin
                  rw_d  = sh[0];
                  ack_d = 1'b1;
               end
            end
            DATA_DONE: begin
               if (!rx_valid || rx_ready) begin
                  rx_data_d = sh;
                  rxv_d     = 1'b1;
                  ack_d     = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
         if (collecting && bit_load) begin
            sh_d  = {sh[6:0], bit_data};
            cnt_d = (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;
         end
         if ((nxt == ADDR || nxt == DATA) && nxt != state) cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_match <= 1'b0;
         rw         <= 1'b0;
         ack_req    <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         overflow   <= 1'b0;
         sh         <= 8'h00;
         bit_cnt    <= 4'd0;
      end else begin
         addr_match <= match_d;
         rw         <= rw_d;
         ack_req    <= ack_d;
         rx_data    <= rx_data_d;
         rx_valid   <= rxv_d;
         overflow   <= ovf_d;
         sh         <= sh_d;
         bit_cnt    <= cnt_d;
      end
   end

   // Decoded straight from the state register, so still free of input paths.
   assign rd_go = collecting;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_i2c_slave_rx_frontend.sv
// Randomized bench for i2c_slave_rx_frontend with a protocol-level reference model.
module tb_i2c_slave_rx_frontend;

   localparam logic [6:0] ADDR = 7'h50;
   localparam int R_IDLE = 0, R_ADDR = 1, R_CHECK = 2, R_DATA = 3, R_IGN = 4;
   localparam int V_NONE = 0, V_ADDR = 1, V_DATA = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start_det = 0, stop_det = 0, bit_data = 0, bit_load = 0;
   logic byte_finish = 0, byte_error = 0, rx_ready = 1;
   logic rd_go, addr_match, rw, ack_req, rx_valid, overflow, busy;
   logic [7:0] rx_data;

   i2c_slave_rx_frontend #(.SLAVE_ADDR(ADDR)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_det(start_det), .stop_det(stop_det),
      .bit_data(bit_data), .bit_load(bit_load), .byte_finish(byte_finish),
      .byte_error(byte_error), .rd_go(rd_go), .addr_match(addr_match), .rw(rw),
      .ack_req(ack_req), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   bit chk_en = 0, rnd_rdy = 0;

   // reference model: protocol role, byte being assembled, pending verdict
   int role, verdict, nbits;
   logic [7:0] mval, e_rxd;
   logic e_go, e_match, e_rw, e_ack, e_rxv, e_ovf, e_busy;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      role = R_IDLE; verdict = V_NONE; nbits = 0; mval = 8'h00; e_rxd = 8'h00;
      e_go = 0; e_match = 0; e_rw = 0; e_ack = 0; e_rxv = 0; e_ovf = 0; e_busy = 0;
   endtask

   // one clock edge with the currently driven inputs, then advance the model
   task automatic clk1();
      logic pre, rdy;
      if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
      pre = e_rxv; rdy = rx_ready;
      @(posedge clk); #1;
      e_ack = 0;
      if (pre && rdy) e_rxv = 0;
      if (start_det) begin
         role = R_ADDR; nbits = 0; e_match = 0; e_ovf = 0; verdict = V_NONE;
      end else if (stop_det) begin
         role = R_IDLE; e_match = 0; verdict = V_NONE;
      end else if (verdict == V_ADDR) begin
         verdict = V_NONE;
         if (mval[7:1] == ADDR) begin
            e_match = 1; e_rw = mval[0]; e_ack = 1; nbits = 0;
            role = mval[0] ? R_IGN : R_DATA;
         end else begin
            e_match = 0; role = R_IGN;
         end
      end else if (verdict == V_DATA) begin
         verdict = V_NONE; role = R_DATA; nbits = 0;
         if (!pre || rdy) begin e_rxd = mval; e_rxv = 1; e_ack = 1; end
         else e_ovf = 1;
      end else if (role == R_ADDR || role == R_DATA) begin
         if (byte_error) role = R_IDLE;
         else if (byte_finish) begin
            if (role == R_ADDR && nbits != 8) role = R_IGN;
            else begin verdict = (role == R_ADDR) ? V_ADDR : V_DATA; role = R_CHECK; end
         end else if (bit_load) begin
            mval = (mval << 1) | {7'd0, bit_data};
            if (nbits < 8) nbits++;
         end
      end
      e_go   = (role == R_ADDR) || (role == R_DATA);
      e_busy = (role != R_IDLE);
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("rd_go", rd_go, e_go);
         chk("addr_match", addr_match, e_match);
         chk("rw", rw, e_rw);
         chk("ack_req", ack_req, e_ack);
         chk("rx_valid", rx_valid, e_rxv);
         chk("overflow", overflow, e_ovf);
         chk("busy", busy, e_busy);
         if (e_rxv) chk("rx_data", rx_data, e_rxd);
      end
   end

   task automatic idle(input int n);
      repeat (n) clk1();
   endtask
   task automatic do_start();
      start_det = 1; clk1(); start_det = 0;
   endtask
   task automatic do_stop();
      stop_det = 1; clk1(); stop_det = 0;
   endtask
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bit_data = v[7-i]; bit_load = 1; clk1(); bit_load = 0;
         idle($urandom_range(0, 1));
      end
   endtask
   // finish strobe plus the one-cycle check slot that follows it
   task automatic fin();
      byte_finish = 1; clk1(); byte_finish = 0; clk1();
   endtask
   task automatic err();
      byte_error = 1; clk1(); byte_error = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      int nd;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_go", rd_go, 0); chk("rst_busy", busy, 0); chk("rst_rxd", rx_data, 8'h00);
      chk("rst_rxv", rx_valid, 0); chk("rst_ack", ack_req, 0);
      rst_n = 1; chk_en = 1;

      // addressed write, one data byte, STOP
      do_start(); chk("s1_go", rd_go, 1);
      send_bits(8'hA0, 8); fin();
      chk("s1_match", addr_match, 1); chk("s1_rw", rw, 0); chk("s1_ack", ack_req, 1);
      send_bits(8'h3C, 8); fin();
      chk("s1_rxd", rx_data, 8'h3C); chk("s1_rxv", rx_valid, 1); chk("s1_ack2", ack_req, 1);
      idle(1); chk("s1_rxv_clr", rx_valid, 0);
      do_stop(); chk("s1_busy", busy, 0); chk("s1_match_clr", addr_match, 0);

      // wrong address: ignored until STOP
      do_start(); send_bits(8'hA2, 8); fin();
      chk("s2_match", addr_match, 0); chk("s2_ack", ack_req, 0); chk("s2_busy", busy, 1);
      send_bits(8'h77, 8); fin(); chk("s2_rxv", rx_valid, 0);
      do_stop();

      // master read
      do_start(); send_bits(8'hA1, 8); fin();
      chk("s3_match", addr_match, 1); chk("s3_rw", rw, 1); chk("s3_ack", ack_req, 1);
      chk("s3_go", rd_go, 0);
      do_stop();

      // back-pressure and overflow
      rx_ready = 0;
      do_start(); send_bits(8'hA0, 8); fin();
      send_bits(8'h11, 8); fin(); chk("s4_ack1", ack_req, 1);
      send_bits(8'h22, 8); fin();
      chk("s4_ack2", ack_req, 0); chk("s4_ovf", overflow, 1); chk("s4_rxd", rx_data, 8'h11);
      rx_ready = 1; idle(1); chk("s4_rxv", rx_valid, 0);
      do_start(); chk("s4_ovf_clr", overflow, 0);
      do_stop();

      // byte error mid data, repeated START mid address byte, short address
      do_start(); send_bits(8'hA0, 8); fin(); send_bits(8'hF0, 4); err();
      chk("s5_busy", busy, 0); chk("s5_rxv", rx_valid, 0);
      do_start(); send_bits(8'hA0, 3); do_start(); send_bits(8'hA0, 8); fin();
      chk("s5_ack", ack_req, 1); chk("s5_match", addr_match, 1);
      do_stop();
      do_start(); send_bits(8'hA0, 5); fin();
      chk("s5_short_ack", ack_req, 0); chk("s5_short_busy", busy, 1);
      do_stop();

      // asynchronous reset with a pending byte
      rx_ready = 0;
      do_start(); send_bits(8'hA0, 8); fin(); send_bits(8'h99, 8); fin();
      send_bits(8'h5A, 3);
      #2 rst_n = 0; #1;
      chk("s6_rxv", rx_valid, 0); chk("s6_go", rd_go, 0); chk("s6_busy", busy, 0);
      chk("s6_match", addr_match, 0); chk("s6_rxd", rx_data, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1; rx_ready = 1;
      do_start(); send_bits(8'hA0, 8); fin(); send_bits(8'h5A, 8); fin();
      chk("s6_rxd2", rx_data, 8'h5A);
      do_stop();

      // randomized transfers
      rnd_rdy = 1;
      for (int t = 0; t < 40; t++) begin
         do_start();
         v = ($urandom_range(0, 1) == 1) ? {ADDR, 1'($urandom_range(0, 1))} : 8'($urandom);
         if ($urandom_range(0, 7) == 0) send_bits(v, $urandom_range(1, 7));
         else send_bits(v, 8);
         fin();
         nd = $urandom_range(0, 4);
         for (int d = 0; d < nd; d++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin send_bits(v, $urandom_range(1, 7)); err(); end
            else begin send_bits(v, 8); fin(); end
         end
         if ($urandom_range(0, 2) != 0) do_stop();
         idle($urandom_range(0, 3));
      end
      rnd_rdy = 0; rx_ready = 1;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
